iob_native_mem_responder: RTL and testbench
===========================================

Name: iob_native_mem_responder

Overview:
- Responder (slave) end of the IOb native bus used by the CPU wrapper's instruction and data ports.
- Accepts flattened request bundles {valid, addr, wdata, wstrb} and returns {rdata, ready} after a programmable number of wait states.
- Backs each request with a word-addressed, byte-strobed internal memory.
- Serves as the on-chip boot/data SRAM responder in the system and as the bus model for CPU-wrapper verification.

Parameters:
- ADDR_W, 32, request address width.
- DATA_W, 32, data width; must be 32.
- MEM_ADDR_W, 10, log2 of memory depth in words.
- WAIT_CYCLES, 1, cycles from request acceptance to the ready pulse; must be >= 1.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- req  input  1+ADDR_W+DATA_W+DATA_W/8  packed {valid, addr, wdata, wstrb}, valid at MSB
- resp  output  DATA_W+1  packed {rdata, ready}, ready at LSB

Behaviour:
- Reset rst, asynchronous, active-high; clock clk.
- Reset values:
  - state=IDLE
  - ready=0
  - rdata=0
  - wait counter=0
  - captured request registers=0
  - memory contents not reset
- Word index = addr[MEM_ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 2**MEM_ADDR_W words. addr[1:0] is ignored; wstrb carries byte lanes.
- Transaction type: wstrb!=0 is a write, wstrb==0 is a read.
- FSM, IDLE:
  - ready=0.
  - If valid=1 at a clk edge, capture addr/wdata/wstrb and load the counter with WAIT_CYCLES-1.
  - Go to RESP if WAIT_CYCLES==1, else go to WAIT.
- FSM, WAIT:
  - ready=0; the counter decrements each cycle.
  - Go to RESP when the counter==0 at the edge (the counter is 1 on entry when WAIT_CYCLES==2).
  - The req contents are ignored; the captured copy is used.
- FSM, RESP:
  - ready=1 for exactly one cycle, then return to IDLE.
  - The valid input is ignored in this cycle. The initiator holds any new request, so a request presented during RESP is accepted in the following IDLE cycle, one bubble later.
- Write:
  - Memory bytes with wstrb[i]=1 are updated on the edge entering RESP; other bytes are unchanged.
  - rdata is unchanged by writes.
- Read:
  - rdata is registered from memory at the word index on the edge entering RESP.
  - rdata holds that value until the next read completes.
- Latency: valid sampled at edge N, ready high in cycle N+WAIT_CYCLES. Throughput is one transaction per WAIT_CYCLES+1 cycles.
- Read after write to the same word returns the new data, because the write commits before the following read samples.
- Reset mid-transaction:
  - Aborts the transaction; the FSM returns to IDLE and ready=0.
  - A pending write that has not reached the RESP edge is not committed.
- Illegal WAIT_CYCLES=0 is treated as 1.

Optional Feature:
- Macro: IOB_MEM_RAND_WAIT_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; reset seed 16'hACE1) advances every cycle.
  - On acceptance, LFSR[1:0] extra wait cycles (0..3) are added to WAIT_CYCLES-1; the FSM enters WAIT whenever the total is nonzero.
  - This stresses initiator hold behaviour.
- When not defined: the wait is fixed at WAIT_CYCLES, with no LFSR logic.

Test Plan:
- Reset: assert rst asynchronously mid-WAIT -> resp=0 immediately; after release, the first request is serviced normally and the aborted write is absent from memory.
- Single write then read, WAIT_CYCLES=1:
  - Write addr=0x10, wdata=0xDEADBEEF, wstrb=0xF -> ready pulses one cycle after acceptance.
  - Read addr=0x10 -> rdata=0xDEADBEEF with ready.
- Byte strobes:
  - Prefill word 0x20 with 0x11223344.
  - Write wdata=0xAABBCCDD, wstrb=0x6 -> read returns 0x11BBCC44.
- Latency, WAIT_CYCLES=4: valid held high from edge N -> ready exactly in cycle N+4, one cycle wide; the next held request gets ready at N+4+1+4.
- Aliasing, MEM_ADDR_W=10:
  - Write 0x12345678 to addr 0x0000_1004.
  - Read addr 0x0000_0004 -> 0x12345678.
  - A read with addr[1:0]=2'b11 at the same word returns the same word.
- With IOB_MEM_RAND_WAIT_EN: 1000 back-to-back random reads/writes against a reference model -> all data match, and every acceptance-to-ready gap is in [WAIT_CYCLES, WAIT_CYCLES+3].

Source files
------------

// File: rtl/iob_native_mem_responder.sv
// IOb native bus responder backed by a byte-strobed word memory with programmable wait states.
// Optional IOB_MEM_RAND_WAIT_EN adds 0..3 LFSR-driven extra wait cycles per transaction.
//
// state | meaning
// IDLE  | waiting for valid; request captured on acceptance
// WAIT  | counting down remaining wait cycles on the captured request
// RESP  | ready pulse for one cycle; memory access committed on entry
module iob_native_mem_responder #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_ADDR_W  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [ADDR_W+DATA_W+DATA_W/8:0]     req,
    output logic [DATA_W:0]                     resp
);

    localparam int STRB_W = DATA_W / 8;
    localparam int WC     = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W  = $clog2(WC + 4);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [MEM_ADDR_W-1:0]   r_idx;
    logic [DATA_W-1:0]       r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_ready;
    logic [DATA_W-1:0]       r_mem [0:(1<<MEM_ADDR_W)-1];

    logic                    w_valid;
    logic [ADDR_W-1:0]       w_req_addr;
    logic [DATA_W-1:0]       w_req_wdata;
    logic [STRB_W-1:0]       w_req_wstrb;
    logic [MEM_ADDR_W-1:0]   w_req_idx;
    logic [CNT_W-1:0]        w_total;
    logic                    w_enter_resp;
    logic [MEM_ADDR_W-1:0]   w_op_idx;
    logic [DATA_W-1:0]       w_op_wdata;
    logic [STRB_W-1:0]       w_op_wstrb;
    logic                    w_unused_addr;

    assign w_valid     = req[ADDR_W+DATA_W+STRB_W];
    assign w_req_addr  = req[DATA_W+STRB_W +: ADDR_W];
    assign w_req_wdata = req[STRB_W +: DATA_W];
    assign w_req_wstrb = req[STRB_W-1:0];
    assign w_req_idx   = w_req_addr[MEM_ADDR_W+1:2];
    // Upper address bits alias and addr[1:0] is superseded by the strobes.
    assign w_unused_addr = ^w_req_addr;

`ifdef IOB_MEM_RAND_WAIT_EN
    logic [15:0] r_lfsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    assign w_total = CNT_W'(WC - 1) + CNT_W'(r_lfsr[1:0]);
`else
    assign w_total = CNT_W'(WC - 1);
`endif

    assign w_enter_resp = ((r_state == IDLE) && w_valid && (w_total == '0)) ||
                          ((r_state == WAIT) && (r_cnt <= CNT_W'(1)));

    // A zero-wait acceptance commits in the same edge, so bypass the capture registers.
    assign w_op_idx   = (r_state == IDLE) ? w_req_idx   : r_idx;
    assign w_op_wdata = (r_state == IDLE) ? w_req_wdata : r_wdata;
    assign w_op_wstrb = (r_state == IDLE) ? w_req_wstrb : r_wstrb;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_wstrb <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_idx   <= w_req_idx;
                        r_wdata <= w_req_wdata;
                        r_wstrb <= w_req_wstrb;
                        r_cnt   <= w_total;
                        if (w_total == '0) begin
                            r_state <= RESP;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_enter_resp) begin
                        r_state <= RESP;
                        r_ready <= 1'b1;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
            if (w_enter_resp && (w_op_wstrb == '0)) begin
                r_rdata <= r_mem[w_op_idx];
            end
        end
    end

    // Memory is not reset; the rst gate keeps a request held during reset from committing.
    always_ff @(posedge clk) begin
        if (w_enter_resp && !rst) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_op_wstrb[i]) begin
                    r_mem[w_op_idx][8*i +: 8] <= w_op_wdata[8*i +: 8];
                end
            end
        end
    end

    assign resp = {r_rdata, r_ready};

endmodule

// File: tb/tb_iob_native_mem_responder.sv
// Directed bench for iob_native_mem_responder: one instance with 1 wait cycle, one with 4.
// Under IOB_MEM_RAND_WAIT_EN a randomized run is checked against a small reference memory.
module tb_iob_native_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [68:0] req1 = '0;
    logic [68:0] req4 = '0;
    logic [32:0] resp1;
    logic [32:0] resp4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    iob_native_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .req  (req1),
        .resp (resp1)
    );

    iob_native_mem_responder #(.ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(10), .WAIT_CYCLES(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .req  (req4),
        .resp (resp4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [3:0] st);
        if (sel == 1) req1 = {v, addr, wd, st};
        else          req4 = {v, addr, wd, st};
    endtask

    function automatic logic [32:0] get_resp(input int sel);
        return (sel == 1) ? resp1 : resp4;
    endfunction

    // Presents a request in IDLE, drops valid after the acceptance edge and waits for ready.
    task automatic xact(input string tag, input int sel, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] st, output logic [31:0] rd);
        logic [32:0] r;
        int lat = 0;
        rd = '0;
        set_req(sel, 1'b1, addr, wd, st);
        for (int i = 1; i <= 20 && lat == 0; i++) begin
            @(posedge clk); #1;
            if (i == 1) set_req(sel, 1'b0, 32'h0, 32'h0, 4'h0);
            r = get_resp(sel);
            if (r[0]) begin
                lat = i;
                rd  = r[32:1];
            end
        end
        if (lat == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
`ifdef IOB_MEM_RAND_WAIT_EN
            check({tag, "_lat_range"}, 32'((lat >= sel) && (lat <= sel + 3)), 32'd1);
`else
            check({tag, "_lat"}, 32'(lat), 32'(sel));
`endif
            @(posedge clk); #1;
            r = get_resp(sel);
            check({tag, "_ready_width"}, {31'd0, r[0]}, 32'd0);
        end
    endtask

    logic [31:0] rd;
    logic [31:0] pattern;
    logic [32:0] r;

`ifdef IOB_MEM_RAND_WAIT_EN
    logic [31:0] model [0:15];
    logic [31:0] addr_r, wd_r, merged;
    logic [3:0]  st_r, idx_r;
`endif

    initial begin
        #2 rst = 1'b1;
        #1;
        check("rst_resp1_rdata", resp1[32:1], 32'h0);
        check("rst_resp1_ready", {31'd0, resp1[0]}, 32'h0);
        check("rst_resp4", {31'd0, resp4[0]}, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        xact("wr10", 1, 32'h10, 32'hDEADBEEF, 4'hF, rd);
        check("wr10_rdata_unchanged", rd, 32'h0);
        xact("rd10", 1, 32'h10, 32'h0, 4'h0, rd);
        check("rd10_data", rd, 32'hDEADBEEF);

        xact("pre20", 1, 32'h20, 32'h11223344, 4'hF, rd);
        xact("strb20", 1, 32'h20, 32'hAABBCCDD, 4'h6, rd);
        check("strb20_rdata_unchanged", rd, 32'hDEADBEEF);
        xact("rd20", 1, 32'h20, 32'h0, 4'h0, rd);
        check("rd20_data", rd, 32'h11BBCC44);

        xact("wr1004", 1, 32'h0000_1004, 32'h12345678, 4'hF, rd);
        xact("rd0004", 1, 32'h0000_0004, 32'h0, 4'h0, rd);
        check("alias_data", rd, 32'h12345678);
        xact("rd0007", 1, 32'h0000_0007, 32'h0, 4'h0, rd);
        check("alias_low_bits", rd, 32'h12345678);

`ifndef IOB_MEM_RAND_WAIT_EN
        // Held valid: accept at k=1, ready after edge 4, re-accept at 6, ready after edge 9.
        pattern = '0;
        set_req(4, 1'b1, 32'h0, 32'hCAFE0000, 4'hF);
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            pattern[k] = resp4[0];
        end
        set_req(4, 1'b0, 32'h0, 32'h0, 4'h0);
        check("held_ready_pattern", pattern, 32'h0000_0210);
`else
        xact("wr0_w4", 4, 32'h0, 32'hCAFE0000, 4'hF, rd);
`endif
        xact("rd0_w4", 4, 32'h0, 32'h0, 4'h0, rd);
        check("rd0_w4_data", rd, 32'hCAFE0000);
        xact("pre08_w4", 4, 32'h8, 32'h01020304, 4'hF, rd);

        // Abort a write mid-WAIT with an asynchronous reset pulse.
        set_req(4, 1'b1, 32'h8, 32'h55AA55AA, 4'hF);
        @(posedge clk); #1;
        set_req(4, 1'b0, 32'h0, 32'h0, 4'h0);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        r = resp4;
        check("abort_rdata_cleared", r[32:1], 32'h0);
        check("abort_ready_low", {31'd0, r[0]}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        xact("rd08_after_abort", 4, 32'h8, 32'h0, 4'h0, rd);
        check("abort_write_absent", rd, 32'h01020304);

`ifdef IOB_MEM_RAND_WAIT_EN
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xact("rand_init", 4, {20'h0, 6'h0, 4'(i), 2'b00}, model[i], 4'hF, rd);
        end
        for (int n = 0; n < 1000; n++) begin
            idx_r  = 4'($urandom_range(0, 15));
            addr_r = {20'($urandom), 6'h0, idx_r, 2'($urandom)};
            wd_r   = $urandom;
            st_r   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            xact("rand", 4, addr_r, wd_r, st_r, rd);
            if (st_r == 4'h0) begin
                check("rand_rdata", rd, model[idx_r]);
            end else begin
                merged = model[idx_r];
                for (int b = 0; b < 4; b++) begin
                    if (st_r[b]) merged[8*b +: 8] = wd_r[8*b +: 8];
                end
                model[idx_r] = merged;
            end
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
